// File: rtl/uart_imem_loader.sv
// UART-driven instruction-memory loader: length header, little-endian words, checksum reply.
// Optional byte echo on TX is enabled by defining UART_LOADER_ECHO_EN.
module uart_imem_loader #(
    parameter int          IMEM_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        Rst,
    input  logic        prog,
    input  logic        rx_data_present,
    input  logic [7:0]  uart_dout,
    output logic        rx_ren,
    input  logic        tx_full,
    output logic        tx_wen,
    output logic [7:0]  uart_din,
    output logic        imem_prog_ena,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_din,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_ACK   = 3'd5;
    localparam logic [2:0] S_DONE  = 3'd6;

    localparam logic [31:0] MAX_WORDS = IMEM_WORDS;
    localparam logic [7:0]  ERR_BYTE  = 8'hEE;

    logic [2:0]  state;
    logic        rx_ren_q;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] words_done;
    logic [1:0]  byte_idx;
    logic [7:0]  checksum;
    logic [15:0] len_rx;
    logic        receiving;
    logic        aborting;
    logic        pop;
    logic        ack_push;

`ifdef UART_LOADER_ECHO_EN
    logic        echo_pend;
    logic [7:0]  echo_byte;
    logic        word_ready;
    logic        echo_push;
`endif

    always_comb begin
        len_rx    = {uart_dout, len_lo};
        receiving = (state == S_LEN0) || (state == S_LEN1) || (state == S_DATA);
        aborting  = !prog && (state != S_IDLE) && (state != S_DONE);
        busy      = (state != S_IDLE) && (state != S_DONE);
        done      = (state == S_DONE);
        imem_en   = (state != S_IDLE);
        imem_prog_ena = (state == S_WRITE) && prog;
`ifdef UART_LOADER_ECHO_EN
        // Pops and the word write wait for the pending echo, so TX/RX/imem strobes never overlap.
        pop       = receiving && prog && rx_data_present && !rx_ren_q && !echo_pend && !word_ready;
        echo_push = echo_pend && prog && !tx_full;
        ack_push  = (state == S_ACK) && prog && !tx_full && !echo_pend;
        tx_wen    = echo_push || ack_push;
        uart_din  = echo_pend ? echo_byte : (err ? ERR_BYTE : checksum);
`else
        pop       = receiving && prog && rx_data_present && !rx_ren_q;
        ack_push  = (state == S_ACK) && prog && !tx_full;
        tx_wen    = ack_push;
        uart_din  = err ? ERR_BYTE : checksum;
`endif
        rx_ren    = pop;
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state      <= S_IDLE;
            rx_ren_q   <= 1'b0;
            len_lo     <= '0;
            len        <= '0;
            words_done <= '0;
            byte_idx   <= '0;
            checksum   <= '0;
            imem_addr  <= BASE_ADDR;
            imem_din   <= '0;
            err        <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
            echo_pend  <= 1'b0;
            echo_byte  <= '0;
            word_ready <= 1'b0;
`endif
        end else begin
            rx_ren_q <= pop;
`ifdef UART_LOADER_ECHO_EN
            if (pop) begin
                echo_pend <= 1'b1;
                echo_byte <= uart_dout;
            end else if (echo_push) begin
                echo_pend <= 1'b0;
            end
`endif
            if (aborting) begin
                state     <= S_IDLE;
                err       <= 1'b1;
                imem_addr <= BASE_ADDR;
`ifdef UART_LOADER_ECHO_EN
                echo_pend  <= 1'b0;
                word_ready <= 1'b0;
`endif
            end else begin
                case (state)
                    S_IDLE: begin
                        if (prog) begin
                            err        <= 1'b0;
                            checksum   <= '0;
                            byte_idx   <= '0;
                            words_done <= '0;
                            imem_addr  <= BASE_ADDR;
                            state      <= S_LEN0;
                        end
                    end
                    S_LEN0: begin
                        if (pop) begin
                            len_lo <= uart_dout;
                            state  <= S_LEN1;
                        end
                    end
                    S_LEN1: begin
                        if (pop) begin
                            len <= len_rx;
                            if (len_rx == 16'd0) begin
                                state <= S_ACK;
                            end else if ({16'd0, len_rx} > MAX_WORDS) begin
                                err   <= 1'b1;
                                state <= S_ACK;
                            end else begin
                                state <= S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (pop) begin
                            imem_din[{byte_idx, 3'b000} +: 8] <= uart_dout;
                            checksum <= checksum + uart_dout;
                            byte_idx <= byte_idx + 2'd1;
                            if (byte_idx == 2'd3) begin
`ifdef UART_LOADER_ECHO_EN
                                word_ready <= 1'b1;
`else
                                state <= S_WRITE;
`endif
                            end
                        end
`ifdef UART_LOADER_ECHO_EN
                        if (word_ready && echo_push) begin
                            word_ready <= 1'b0;
                            state      <= S_WRITE;
                        end
`endif
                    end
                    S_WRITE: begin
                        imem_addr  <= imem_addr + 32'd4;
                        words_done <= words_done + 16'd1;
                        state      <= (words_done + 16'd1 < len) ? S_DATA : S_ACK;
                    end
                    S_ACK: begin
                        if (ack_push) state <= S_DONE;
                    end
                    S_DONE: begin
                        if (!prog) begin
                            state     <= S_IDLE;
                            imem_addr <= BASE_ADDR;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Directed testbench for uart_imem_loader with an RX FIFO model and strobe monitors.
module tb_uart_imem_loader;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        prog = 1'b0;
    logic        rx_data_present = 1'b0;
    logic [7:0]  uart_dout = 8'h00;
    logic        rx_ren;
    logic        tx_full = 1'b0;
    logic        tx_wen;
    logic [7:0]  uart_din;
    logic        imem_prog_ena;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_din;
    logic        busy;
    logic        done;
    logic        err;

    uart_imem_loader #(.IMEM_WORDS(4096), .BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .Rst(Rst), .prog(prog),
        .rx_data_present(rx_data_present), .uart_dout(uart_dout), .rx_ren(rx_ren),
        .tx_full(tx_full), .tx_wen(tx_wen), .uart_din(uart_din),
        .imem_prog_ena(imem_prog_ena), .imem_en(imem_en),
        .imem_addr(imem_addr), .imem_din(imem_din),
        .busy(busy), .done(done), .err(err)
    );

    always #10 clk = ~clk;

    logic [7:0]  rx_q[$];
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    logic [7:0]  tx_q[$];
    int          tx_cyc[$];
    int          cyc = 0;
    int          consec_viol = 0;
    int          overlap = 0;
    int          rx_pops = 0;
    logic        rx_ren_prev = 1'b0;
    logic        pop_pend = 1'b0;
    int          checks = 0;
    int          errors = 0;

    task automatic update_rx();
        rx_data_present = (rx_q.size() != 0);
        uart_dout = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // The DUT captures the head byte on the edge after rx_ren; the model drops it one half-cycle later.
    always @(negedge clk) begin
        cyc++;
        if (!Rst) begin
            if (rx_ren && rx_ren_prev) consec_viol++;
            if ((int'(rx_ren) + int'(tx_wen) + int'(imem_prog_ena)) > 1) overlap++;
            if (rx_ren) rx_pops++;
            if (imem_prog_ena) begin
                wr_addr.push_back(imem_addr);
                wr_data.push_back(imem_din);
            end
            if (tx_wen) begin
                tx_q.push_back(uart_din);
                tx_cyc.push_back(cyc);
            end
        end
        rx_ren_prev = rx_ren;
        if (pop_pend && rx_q.size() != 0) void'(rx_q.pop_front());
        pop_pend = rx_ren;
        update_rx();
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        tx_q.delete();
        tx_cyc.delete();
        consec_viol = 0;
        overlap = 0;
        rx_pops = 0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic finish_load();
        prog = 1'b0;
        step(3);
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        step(3);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (imem_en !== 1'b0) begin errors++; $display("FAIL reset_imem_en: got %b expected 0", imem_en); end
        checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 00000000", imem_addr); end
        checks++; if (imem_din !== 32'h0) begin errors++; $display("FAIL reset_din: got %h expected 00000000", imem_din); end
        checks++; if ({rx_ren, tx_wen, imem_prog_ena} !== 3'b000) begin errors++; $display("FAIL reset_strobes: got %b expected 000", {rx_ren, tx_wen, imem_prog_ena}); end
        checks++; if (uart_din !== 8'h00) begin errors++; $display("FAIL reset_uart_din: got %h expected 00", uart_din); end
        Rst = 1'b0;
        step(1);
    endtask

    task automatic test_basic_load();
        bit ok;
        logic [7:0] exp_last;
        int exp_ntx;
        clear_logs();
        rx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        update_rx();
        prog = 1'b1;
        wait_done(300, ok);
        exp_last = 8'hB6;
`ifdef UART_LOADER_ECHO_EN
        exp_ntx = 11;
`else
        exp_ntx = 1;
`endif
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_timeout: done=%b expected 1 within budget", done); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL basic_nwrites: got %0d expected 2", wr_addr.size()); end
        checks++; if (wr_addr[0] !== 32'h0 || wr_data[0] !== 32'h0000_0013) begin errors++; $display("FAIL basic_word0: got %h@%h expected 00000013@00000000", wr_data[0], wr_addr[0]); end
        checks++; if (wr_addr[1] !== 32'h4 || wr_data[1] !== 32'h0010_0093) begin errors++; $display("FAIL basic_word1: got %h@%h expected 00100093@00000004", wr_data[1], wr_addr[1]); end
        checks++; if (tx_q.size() !== exp_ntx) begin errors++; $display("FAIL basic_ntx: got %0d expected %0d", tx_q.size(), exp_ntx); end
        checks++; if (tx_q[$] !== exp_last) begin errors++; $display("FAIL basic_checksum: got %h expected %h", tx_q[$], exp_last); end
        checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL basic_flags: err=%b busy=%b expected 0 0", err, busy); end
        checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL basic_final_addr: got %h expected 00000008", imem_addr); end
        finish_load();
        checks++; if (done !== 1'b0 || imem_addr !== 32'h0) begin errors++; $display("FAIL basic_release: done=%b addr=%h expected 0 00000000", done, imem_addr); end
    endtask

    task automatic test_zero_len();
        bit ok;
        clear_logs();
        rx_q = '{8'h00, 8'h00};
        update_rx();
        prog = 1'b1;
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zero_timeout: done=%b expected 1 within budget", done); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL zero_nwrites: got %0d expected 0", wr_addr.size()); end
        checks++; if (tx_q[$] !== 8'h00) begin errors++; $display("FAIL zero_txbyte: got %h expected 00", tx_q[$]); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL zero_err: got %b expected 0", err); end
        finish_load();
    endtask

    task automatic test_too_long();
        bit ok;
        clear_logs();
        rx_q = '{8'h01, 8'h10};
        update_rx();
        prog = 1'b1;
        wait_done(100, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL long_timeout: done=%b expected 1 within budget", done); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL long_err: got %b expected 1", err); end
        checks++; if (tx_q[$] !== 8'hEE) begin errors++; $display("FAIL long_txbyte: got %h expected ee", tx_q[$]); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL long_nwrites: got %0d expected 0", wr_addr.size()); end
        finish_load();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL long_err_sticky: got %b expected 1", err); end
    endtask

    task automatic test_abort();
        bit ok;
        int i;
        clear_logs();
        rx_q = '{8'h04, 8'h00, 8'hAA, 8'hBB};
        update_rx();
        prog = 1'b1;
        for (i = 0; i < 100 && rx_pops < 4; i++) step(1);
        checks++; if (rx_pops !== 4) begin errors++; $display("FAIL abort_pops: got %0d expected 4", rx_pops); end
        prog = 1'b0;
        step(2);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL abort_err: got %b expected 1", err); end
        checks++; if (busy !== 1'b0 || imem_en !== 1'b0) begin errors++; $display("FAIL abort_idle: busy=%b imem_en=%b expected 0 0", busy, imem_en); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL abort_nwrites: got %0d expected 0", wr_addr.size()); end
        rx_q.delete();
        update_rx();
        step(2);
        clear_logs();
        rx_q = '{8'h01, 8'h00, 8'h37, 8'h12, 8'h00, 8'h00};
        update_rx();
        prog = 1'b1;
        step(2);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL abort_err_clear: got %b expected 0", err); end
        wait_done(200, ok);
        checks++; if (ok !== 1'b1 || wr_addr.size() !== 1) begin errors++; $display("FAIL abort_reload: done=%b nwrites=%0d expected 1 1", ok, wr_addr.size()); end
        checks++; if (wr_data[0] !== 32'h0000_1237 || wr_addr[0] !== 32'h0) begin errors++; $display("FAIL abort_reload_word: got %h@%h expected 00001237@00000000", wr_data[0], wr_addr[0]); end
        checks++; if (tx_q[$] !== 8'h49) begin errors++; $display("FAIL abort_reload_sum: got %h expected 49", tx_q[$]); end
        finish_load();
    endtask

    task automatic test_tx_full();
        bit ok;
        int rel;
        int exp_ntx;
        clear_logs();
        tx_full = 1'b1;
        rx_q = '{8'h00, 8'h00};
        update_rx();
        prog = 1'b1;
        step(20);
        checks++; if (tx_q.size() !== 0) begin errors++; $display("FAIL txfull_held: got %0d pushes expected 0", tx_q.size()); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL txfull_busy: got %b expected 1", busy); end
        tx_full = 1'b0;
        rel = cyc;
        wait_done(50, ok);
`ifdef UART_LOADER_ECHO_EN
        exp_ntx = 3;
`else
        exp_ntx = 1;
`endif
        checks++; if (ok !== 1'b1 || tx_q.size() !== exp_ntx) begin errors++; $display("FAIL txfull_count: done=%b pushes=%0d expected 1 %0d", ok, tx_q.size(), exp_ntx); end
        checks++; if (tx_cyc[0] !== rel + 1) begin errors++; $display("FAIL txfull_first_cycle: got %0d expected %0d", tx_cyc[0], rel + 1); end
        checks++; if (tx_q[$] !== 8'h00) begin errors++; $display("FAIL txfull_byte: got %h expected 00", tx_q[$]); end
        finish_load();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] exp_tx[$];
        int nbad;
        clear_logs();
`ifdef UART_LOADER_ECHO_EN
        exp_tx = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
`else
        exp_tx = '{8'hB6};
`endif
        rx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        update_rx();
        prog = 1'b1;
        wait_done(300, ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout: done=%b expected 1 within budget", done); end
        checks++; if (consec_viol !== 0) begin errors++; $display("FAIL b2b_rx_ren_consecutive: got %0d expected 0", consec_viol); end
        checks++; if (overlap !== 0) begin errors++; $display("FAIL b2b_strobe_overlap: got %0d expected 0", overlap); end
        checks++; if (rx_pops !== 10) begin errors++; $display("FAIL b2b_pops: got %0d expected 10", rx_pops); end
        nbad = (tx_q.size() == exp_tx.size()) ? 0 : 1;
        for (int i = 0; i < exp_tx.size() && i < tx_q.size(); i++)
            if (tx_q[i] !== exp_tx[i]) nbad++;
        checks++; if (nbad !== 0) begin errors++; $display("FAIL b2b_tx_sequence: got %0d bytes (%0d wrong) expected %0d bytes", tx_q.size(), nbad, exp_tx.size()); end
        finish_load();
    endtask

    initial begin
        test_reset();
        test_basic_load();
        test_zero_len();
        test_too_long();
        test_abort();
        test_tx_full();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
